// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared memory port: the I-cache and D-cache each move whole
// line bursts. The D-cache wins contention until the I-cache has waited STARVE_MAX grants.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int BEATS      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic              icache_gnt_o,
  output logic [DATA_W-1:0] icache_rdata_o,
  output logic              icache_rvalid_o,
  output logic              icache_done_o,
  input  logic              dcache_req_i,
  input  logic              dcache_we_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [DATA_W-1:0] dcache_wdata_i,
  output logic              dcache_gnt_o,
  output logic [DATA_W-1:0] dcache_rdata_o,
  output logic              dcache_rvalid_o,
  output logic              dcache_wready_o,
  output logic              dcache_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int BYTES    = DATA_W / 8;
  localparam int BYTE_SH  = $clog2(BYTES);
  localparam int OFF_W    = $clog2(BEATS * BYTES);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0]   BASE_MASK  = {ADDR_W{1'b1}} << OFF_W;

  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;   // 1 = D-cache owns the burst
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                gnt_q, gnt_d;

  logic                pick_d_s;
  logic                in_burst_s;
  logic                in_done_s;
  logic                rd_beat_s;
  logic [ADDR_W-1:0]   beat_off_s;

  assign pick_d_s = dcache_req_i & (~icache_req_i | (starve_q != STARVE_LIM));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    base_d   = base_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    gnt_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (icache_req_i || dcache_req_i) begin
          state_d = S_BURST;
          owner_d = pick_d_s;
          we_d    = pick_d_s & dcache_we_i;
          base_d  = (pick_d_s ? dcache_addr_i : icache_addr_i) & BASE_MASK;
          beat_d  = {BEAT_W{1'b0}};
          gnt_d   = 1'b1;
          // Only a D grant that actually overtakes a waiting I request counts.
          if (!pick_d_s) begin
            starve_d = {STARVE_W{1'b0}};
          end else if (icache_req_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_W'(1);
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (mem_ack_i) begin
          beat_d  = beat_q + BEAT_W'(1);
          state_d = (beat_q == LAST_BEAT) ? S_DONE : S_BURST;
        end else begin
          state_d = S_BURST;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= {ADDR_W{1'b0}};
      beat_q   <= {BEAT_W{1'b0}};
      starve_q <= {STARVE_W{1'b0}};
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
    end
  end

  assign in_burst_s = (state_q == S_BURST);
  assign in_done_s  = (state_q == S_DONE);
  assign rd_beat_s  = in_burst_s & mem_ack_i & ~we_q;
  assign beat_off_s = ADDR_W'(beat_q) << BYTE_SH;

  assign mem_req_o   = in_burst_s;
  assign mem_we_o    = in_burst_s & we_q;
  assign mem_addr_o  = in_burst_s ? (base_q + beat_off_s) : {ADDR_W{1'b0}};
  assign mem_wdata_o = in_burst_s ? dcache_wdata_i : {DATA_W{1'b0}};

  assign icache_gnt_o    = gnt_q & ~owner_q;
  assign icache_rvalid_o = rd_beat_s & ~owner_q;
  assign icache_rdata_o  = icache_rvalid_o ? mem_rdata_i : {DATA_W{1'b0}};
  assign icache_done_o   = in_done_s & ~owner_q;

  assign dcache_gnt_o    = gnt_q & owner_q;
  assign dcache_rvalid_o = rd_beat_s & owner_q;
  assign dcache_rdata_o  = dcache_rvalid_o ? mem_rdata_i : {DATA_W{1'b0}};
  assign dcache_wready_o = in_burst_s & mem_ack_i & we_q & owner_q;
  assign dcache_done_o   = in_done_s & owner_q;

  assign busy_o = (state_q != S_IDLE);

endmodule
